dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 64-word data memory in the MIPS subsystem.
- Requester 0 is the CPU load/store port; requester 1 is the FIFO/DMA side.
- Accepts req/gnt handshakes, applies round-robin, and drives the memory for exactly one cycle per access.
- Returns registered read data with a done pulse.
- The memory writes on the falling edge of clk and reads combinationally.

---
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port 64-word data memory.
// Each accepted access drives the memory for exactly one cycle; read data returns registered with a done pulse.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int ADDR_SHIFT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          done0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          done1,
    output logic [DW-1:0] rdata1,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic          cur;
    logic          last_grant;
    logic          we_lat;
    logic [AW-1:0] a_lat;
    logic [DW-1:0] wd_lat;

    logic          elig0;
    logic          elig1;
    logic          win;

    // The requester finishing its BUSY cycle is not eligible, so the other side can follow back-to-back.
    always_comb begin
        elig0 = req0 && !(state == BUSY && !cur);
        elig1 = req1 && !(state == BUSY && cur);
        win   = (elig0 && elig1) ? ~last_grant : elig1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= 1'b0;
            last_grant <= 1'b1;
            we_lat     <= 1'b0;
            a_lat      <= '0;
            wd_lat     <= '0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            done0 <= (state == BUSY) && !cur;
            done1 <= (state == BUSY) && cur;
            if (state == BUSY && !we_lat) begin
                if (cur) rdata1 <= mem_rd;
                else     rdata0 <= mem_rd;
            end
            if (elig0 || elig1) begin
                state      <= BUSY;
                cur        <= win;
                last_grant <= win;
                we_lat     <= win ? we1 : we0;
                a_lat      <= (win ? addr1 : addr0) >> ADDR_SHIFT;
                wd_lat     <= win ? wdata1 : wdata0;
            end else begin
                state <= IDLE;
            end
        end
    end

    assign gnt0   = (state == BUSY) && !cur;
    assign gnt1   = (state == BUSY) && cur;
    // Reset aborts an in-flight write before the falling edge commits it.
    assign mem_we = (state == BUSY) && we_lat && !reset;
    assign mem_a  = a_lat;
    assign mem_wd = wd_lat;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level reference model predicts grants and
// read data; a negedge monitor compares everything the DUT presents.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, done0, gnt1, done1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;

    int total = 0;
    int bad   = 0;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: falling-edge write, combinational read.
    logic [31:0] mem [64];
    assign mem_rd = mem[mem_a[5:0]];
    always @(negedge clk) if (mem_we) mem[mem_a[5:0]] <= mem_wd;

    typedef struct packed {
        logic        who;
        logic        rd;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (transaction view)
    logic [31:0] ref_mem [64];
    bit          m_started = 0;
    bit          m_busy, m_cur, m_last, m_we;
    logic [31:0] m_idx, m_wd;
    bit          p_done0, p_done1;
    logic [31:0] exp_rd0, exp_rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit e0, e1, w;
        if (reset) begin
            m_busy = 0; m_cur = 0; m_last = 1; m_we = 0;
            p_done0 = 0; p_done1 = 0;
            exp_rd0 = '0; exp_rd1 = '0;
            exp_q.delete();
        end else begin
            p_done0 = m_busy && !m_cur;
            p_done1 = m_busy && m_cur;
            if (m_busy && m_we) ref_mem[m_idx[5:0]] = m_wd;
            e0 = req0 && !(m_busy && !m_cur);
            e1 = req1 && !(m_busy && m_cur);
            if (e0 || e1) begin
                w      = (e0 && e1) ? !m_last : e1;
                m_busy = 1; m_cur = w; m_last = w;
                m_we   = w ? we1 : we0;
                m_idx  = (w ? addr1 : addr0) >> 2;
                m_wd   = w ? wdata1 : wdata0;
                exp_q.push_back('{who: w, rd: !m_we, data: ref_mem[m_idx[5:0]]});
            end else begin
                m_busy = 0;
            end
        end
        m_started = 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (m_started) begin
            chk("gnt0", gnt0, m_busy && !m_cur);
            chk("gnt1", gnt1, m_busy && m_cur);
            chk("mem_we", mem_we, m_busy && m_we && !reset);
            if (m_busy) begin
                chk("mem_a", mem_a, m_idx);
                chk("mem_wd", mem_wd, m_wd);
            end
            chk("done0", done0, p_done0);
            chk("done1", done1, p_done1);
            if (done0 || done1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected: got done with empty scoreboard want none");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_who", done1, e.who);
                    if (e.rd) begin
                        if (e.who) exp_rd1 = e.data;
                        else       exp_rd0 = e.data;
                    end
                end
            end
            chk("rdata0", rdata0, exp_rd0);
            chk("rdata1", rdata1, exp_rd1);
        end
    end

    task automatic set_req(input int r, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        if (r == 0) begin req0 = v; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = v; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic issue(input int r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int wd_after);
        int  n = 0;
        bit  fin = 0;
        set_req(r, 1'b1, w, a, d);
        while (!fin) begin
            @(posedge clk); #2;
            if ((r == 0 && gnt0) || (r == 1 && gnt1)) fin = 1;
            else if (n >= wd_after) fin = 1;
            else begin
                n++;
                if (n > 40) begin
                    total++; bad++;
                    $display("FAIL grant_timeout: requester %0d got no grant want grant", r);
                    fin = 1;
                end
            end
        end
        set_req(r, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g1cnt;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hC0DE0000 ^ (i * 32'h01010101);
            ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h01010101);
        end
        reset = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h4, 32'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Contention: requester 0 wins the first tie, then strict alternation
        @(posedge clk); #2;
        chk("first_gnt0", gnt0, 1'b1);
        chk("first_gnt1", gnt1, 1'b0);
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #2;
            chk("alt_gnt0", gnt0, (k % 2) == 0);
            chk("alt_gnt1", gnt1, (k % 2) == 1);
        end
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        idle(3);

        // Single write then read
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        @(posedge clk); #2;
        chk("wr_gnt0", gnt0, 1'b1);
        chk("wr_mem_a", mem_a, 32'd4);
        chk("wr_mem_we", mem_we, 1'b1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        chk("wr_done0", done0, 1'b1);
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #2;
        chk("rd_gnt0", gnt0, 1'b1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #2;
        chk("rd_done0", done0, 1'b1);
        chk("rd_rdata0", rdata0, 32'hDEADBEEF);
        idle(2);

        // Same requester held: one access every other cycle
        g1cnt = 0;
        set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
        repeat (8) begin @(posedge clk); #2; if (gnt1) g1cnt++; end
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("b2b_gnt1_count", g1cnt, 4);
        idle(2);

        // Withdraw: requester 1 loses the tie and drops before being served
        set_req(0, 1'b1, 1'b0, 32'hC, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h14, 32'h55);
        @(posedge clk); #2;
        chk("wd_gnt0", gnt0, 1'b1);
        chk("wd_gnt1", gnt1, 1'b0);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        repeat (3) begin @(posedge clk); #2; chk("wd_no_gnt1", gnt1, 1'b0); end
        issue(0, 1'b0, 32'h14, 32'h0, 100);
        idle(3);

        // Reset during a BUSY write cycle
        set_req(0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        @(posedge clk); #2;
        chk("rst_gnt0", gnt0, 1'b1);
        set_req(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_we", mem_we, 1'b0);
        @(posedge clk); #2;
        reset = 1'b0;
        chk("rst_no_done0", done0, 1'b0);
        chk("rst_idle_gnt0", gnt0, 1'b0);
        idle(1);
        issue(0, 1'b0, 32'h20, 32'h0, 100);
        idle(3);

        // Randomized traffic from both requesters
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    idle($urandom_range(0, 2));
                    issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
                          ($urandom_range(0, 9) == 0) ? 0 : 100);
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    idle($urandom_range(0, 2));
                    issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
                          ($urandom_range(0, 9) == 0) ? 0 : 100);
                end
            end
        join
        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
